// File: rtl/move_pkg.sv
// move_pkg: shared constants and the segment record for the move buffer.
//   MOVE_WORD_W     - width of duration / increment / increment-increment
//   MOVE_DEPTH_BITS - default log2 of the entry count
//   move_seg_t      - one complete coordinated-move segment
package move_pkg;
    localparam int MOVE_WORD_W = 64;
    localparam int MOVE_DEPTH_BITS = 2;
    typedef struct packed {
        logic                   dir;
        logic [MOVE_WORD_W-1:0] duration;
        logic [MOVE_WORD_W-1:0] increment;
        logic [MOVE_WORD_W-1:0] incrinc;
    } move_seg_t;
endpackage

// File: rtl/move_buffer_if.sv
// move_buffer_if: producer/consumer bus of the move buffer.
//   clear, wr_* : producer side (segment offer, flush request, wr_ready back)
//   rd_*        : consumer side (head entry, rd_ready back)
//   count, overflow, zero_dur : occupancy and sticky error status
//   moves_done, underruns     : statistics, present only with MOVE_BUFFER_STATS_EN
// slave is the buffer's view, master is the view of the surrounding logic.
interface move_buffer_if import move_pkg::*; #(
    parameter int DEPTH_BITS = MOVE_DEPTH_BITS,
    parameter int WORD_W = MOVE_WORD_W
);
    logic              clear;
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_dir;
    logic [WORD_W-1:0] wr_duration;
    logic [WORD_W-1:0] wr_increment;
    logic [WORD_W-1:0] wr_incrinc;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_dir;
    logic [WORD_W-1:0] rd_duration;
    logic [WORD_W-1:0] rd_increment;
    logic [WORD_W-1:0] rd_incrinc;
    logic [DEPTH_BITS:0] count;
    logic              overflow;
    logic              zero_dur;
`ifdef MOVE_BUFFER_STATS_EN
    logic [31:0]       moves_done;
    logic [15:0]       underruns;
`endif
    modport slave (
        input  clear, wr_valid, wr_dir, wr_duration, wr_increment, wr_incrinc, rd_ready,
        output wr_ready, rd_valid, rd_dir, rd_duration, rd_increment, rd_incrinc,
        output count, overflow, zero_dur
`ifdef MOVE_BUFFER_STATS_EN
        , output moves_done, underruns
`endif
    );
    modport master (
        output clear, wr_valid, wr_dir, wr_duration, wr_increment, wr_incrinc, rd_ready,
        input  wr_ready, rd_valid, rd_dir, rd_duration, rd_increment, rd_incrinc,
        input  count, overflow, zero_dur
`ifdef MOVE_BUFFER_STATS_EN
        , input moves_done, underruns
`endif
    );
endinterface

// File: rtl/move_buffer_mem.sv
// move_buffer_mem: segment storage, one write port and one asynchronous read port.
//   CLK          - write clock
//   we/waddr/wdata - write port
//   raddr/rd_en  - read address; rdata is forced to 0 when rd_en is low so the
//                  head fields never expose uninitialised storage
// The array is deliberately not reset.
module move_buffer_mem import move_pkg::*; #(
    parameter int DEPTH_BITS = MOVE_DEPTH_BITS
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] waddr,
    input  move_seg_t             wdata,
    input  logic [DEPTH_BITS-1:0] raddr,
    input  logic                  rd_en,
    output move_seg_t             rdata
);
    move_seg_t mem_q [1<<DEPTH_BITS];
    always_ff @(posedge CLK)
        if (we) mem_q[waddr] <= wdata;
    assign rdata = rd_en ? mem_q[raddr] : '0;
endmodule

// File: rtl/move_buffer.sv
// move_buffer: first-word fall-through FIFO of move segments between the SPI
// message handler and the DDA step-timing engine.
//   CLK    - system clock
//   resetn - asynchronous active-low reset, discards all entries
//   bus    - move_buffer_if.slave: clear, write handshake, read handshake,
//            count and sticky overflow / zero_dur flags
// Optional macro MOVE_BUFFER_STATS_EN adds saturating moves_done/underruns counters.
// WORD_W must equal MOVE_WORD_W since entries are stored as move_seg_t.
module move_buffer import move_pkg::*; #(
    parameter int DEPTH_BITS = MOVE_DEPTH_BITS,
    parameter int WORD_W = MOVE_WORD_W
) (
    input logic         CLK,
    input logic         resetn,
    move_buffer_if.slave bus
);
    localparam int CW = DEPTH_BITS + 1;
    localparam logic [DEPTH_BITS:0] DEPTH_C = CW'(1 << DEPTH_BITS);
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d, zero_dur_q, zero_dur_d;
    logic                  full, empty, dur_zero, push, pop;
    move_seg_t             wseg, rseg;
    // Full/empty come from the registered count only, so wr_ready has no path from rd_ready.
    assign full     = count_q == DEPTH_C;
    assign empty    = count_q == '0;
    assign dur_zero = bus.wr_duration == WORD_W'(0);
    assign push     = bus.wr_valid && !full && !dur_zero && !bus.clear;
    assign pop      = bus.rd_ready && !empty && !bus.clear;
    assign wseg     = {bus.wr_dir, bus.wr_duration, bus.wr_increment, bus.wr_incrinc};
    always_comb begin
        wr_ptr_d   = bus.clear ? '0 : push ? wr_ptr_q + DEPTH_BITS'(1) : wr_ptr_q;
        rd_ptr_d   = bus.clear ? '0 : pop ? rd_ptr_q + DEPTH_BITS'(1) : rd_ptr_q;
        count_d    = bus.clear ? '0 : (push && !pop) ? count_q + CW'(1) :
                     (!push && pop) ? count_q - CW'(1) : count_q;
        overflow_d = !bus.clear && (overflow_q || (bus.wr_valid && full));
        zero_dur_d = !bus.clear && (zero_dur_q || (bus.wr_valid && dur_zero));
    end
    always_ff @(posedge CLK or negedge resetn)
        if (!resetn) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            zero_dur_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            zero_dur_q <= zero_dur_d;
        end
    move_buffer_mem #(.DEPTH_BITS(DEPTH_BITS)) u_mem (
        .CLK   (CLK),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wseg),
        .raddr (rd_ptr_q),
        .rd_en (!empty),
        .rdata (rseg)
    );
    assign bus.wr_ready     = !full;
    assign bus.rd_valid     = !empty;
    assign bus.rd_dir       = rseg.dir;
    assign bus.rd_duration  = rseg.duration;
    assign bus.rd_increment = rseg.increment;
    assign bus.rd_incrinc   = rseg.incrinc;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.zero_dur     = zero_dur_q;
`ifdef MOVE_BUFFER_STATS_EN
    logic [31:0] moves_done_q, moves_done_d;
    logic [15:0] underruns_q, underruns_d;
    logic        prev_valid_q;
    // An underrun is the consumer still asking right after the buffer ran dry.
    logic        underrun;
    assign underrun = bus.rd_ready && empty && prev_valid_q;
    always_comb begin
        moves_done_d = bus.clear ? '0 : (pop && moves_done_q != '1) ? moves_done_q + 32'd1 : moves_done_q;
        underruns_d  = bus.clear ? '0 : (underrun && underruns_q != '1) ? underruns_q + 16'd1 : underruns_q;
    end
    always_ff @(posedge CLK or negedge resetn)
        if (!resetn) begin
            moves_done_q <= '0;
            underruns_q  <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            moves_done_q <= moves_done_d;
            underruns_q  <= underruns_d;
            prev_valid_q <= !empty;
        end
    assign bus.moves_done = moves_done_q;
    assign bus.underruns  = underruns_q;
`endif
endmodule

// File: doc/move_buffer.md
Name: move_buffer

Overview:
- Multi-entry FIFO of coordinated-move segments.
- Sits between the SPI word/message handler (producer) and the DDA step-timing engine (consumer).
- Each entry holds one complete segment: direction, duration in ticks, initial increment and increment-increment.
- Replaces toggle-flag latching with a valid/ready handshake, occupancy reporting and sticky error flags.

Parameters:
- DEPTH_BITS, 2, log2 of entry count; depth = 2**DEPTH_BITS (default 4 entries).
- WORD_W, 64, width of the duration, increment and increment-increment fields.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of all entries and error flags.
- wr_valid  in  1  producer presents a segment.
- wr_ready  out  1  buffer can accept a segment this cycle.
- wr_dir  in  1  segment direction.
- wr_duration  in  WORD_W  segment length in DDA ticks (unsigned).
- wr_increment  in  WORD_W  initial increment (signed).
- wr_incrinc  in  WORD_W  increment-increment (signed).
- rd_valid  out  1  head entry is available.
- rd_ready  in  1  consumer takes the head entry.
- rd_dir, rd_duration, rd_increment, rd_incrinc  out  1/WORD_W/WORD_W/WORD_W  head entry fields.
- count  out  DEPTH_BITS+1  current occupancy, 0..depth.
- overflow  out  1  sticky: a write was attempted while full.
- zero_dur  out  1  sticky: a segment with duration 0 was offered.

Behaviour:
- Reset (resetn low, asynchronous): pointers 0, count 0, rd_valid 0, wr_ready 1, overflow 0, zero_dur 0, rd_* fields 0.
- Reset may be asserted mid-operation; all stored segments are discarded immediately.
- Release of resetn is synchronised by the caller.
- Push occurs on an edge where wr_valid & wr_ready & (wr_duration != 0).
- Pop occurs on an edge where rd_valid & rd_ready.
- wr_ready = (count != depth); derived from registered count only, with no combinational path from rd_ready.
- Behaviour is first-word fall-through:
  - rd_* always shows the entry at the read pointer.
  - Push into an empty buffer at edge N gives rd_valid=1 and valid rd_* in the cycle after edge N (1-cycle latency).
- rd_* fields are don't-care while rd_valid=0 but must not be X after reset.
- Count update:
  - push only: count + 1.
  - pop only: count - 1.
  - both: unchanged, and both pointers advance.
- Full + wr_valid:
  - Write is dropped and overflow set.
  - A same-cycle pop still occurs, but the write is not accepted that cycle (wr_ready is registered).
- Empty + rd_ready: no effect.
- wr_valid with wr_duration == 0:
  - Entry is not stored and zero_dur is set.
  - wr_ready is unaffected, so the producer sees the segment as accepted.
- Pointers are DEPTH_BITS wide and wrap modulo depth.
- Full/empty are determined from count, not from pointer equality.
- clear has priority over push and pop in the same cycle: pointers and count go to 0, overflow and zero_dur go to 0, and the same-cycle push is dropped without setting any flag.
- Sticky flags clear only on reset or clear.
- Entry fields are stored verbatim; the buffer performs no arithmetic on them.

Optional Feature:
- Macro: MOVE_BUFFER_STATS_EN.
- Defined:
  - Adds outputs moves_done (32 bit) and underruns (16 bit).
  - moves_done increments on every pop.
  - underruns increments on each cycle where rd_ready=1 and count=0 but the previous cycle had rd_valid=1 (consumer starved after draining).
  - Both counters saturate at all-ones, reset to 0, and are cleared by clear.
- Not defined: the ports and their logic are absent, and the remaining behaviour is unchanged.

Decomposition:
- Shared package (move_pkg):
  - Constant MOVE_WORD_W = 64.
  - Typedef move_seg_t (dir, duration, increment, incrinc), packed, total width 1 + 3*MOVE_WORD_W.
  - Default DEPTH_BITS constant.
- Sub-module move_buffer_mem:
  - Depth x move_seg_t register array with one write port and one asynchronous read port.
  - No reset on the array itself; the read mux output is gated to 0 when empty.
- Control logic (pointers, count, flags, stats) stays in move_buffer.

Test Plan:
- Push 4 segments (dur 10,20,30,40; dir 1,0,1,0) with rd_ready=0 -> count=4, wr_ready=0, rd_duration=10, rd_dir=1; a 5th push sets overflow=1 and count stays 4.
- Hold rd_ready=1 and pop all 4 -> rd_duration sequence 10,20,30,40 on consecutive cycles, then rd_valid=0 and count=0.
- Simultaneous push and pop with count=2 for 10 cycles -> count stays 2, data order preserved across pointer wrap-around, and rd_increment matches the write sequence.
- Push a segment with wr_duration=0 -> count unchanged, zero_dur=1; then assert clear with wr_valid=1 -> count=0, zero_dur=0, overflow=0, and nothing stored.
- Fill 3 entries, then pulse resetn low asynchronously mid-cycle -> count=0, rd_valid=0 immediately; after release, a new push gives rd_valid=1 one cycle later.
- With MOVE_BUFFER_STATS_EN: 5 pops, then rd_ready held while empty -> moves_done=5, underruns=1.
